// File: rtl/exu_inst_buf_if.sv
`default_nettype none
// ============================================================================
// exu_inst_buf_if : fetch-side and EXU-side handshake bundle of the buffer
// Revision 1.0
// ============================================================================
interface exu_inst_buf_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int XLEN  = 32
);
    logic             flush;
    logic             in_vld;
    logic             in_rdy;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             out_vld;
    logic             out_rdy;
    logic [31:0]      out_inst;
    logic [XLEN-1:0]  out_pc;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, in_vld, in_inst, in_pc, out_rdy,
        input  in_rdy, out_vld, out_inst, out_pc, count
    );

    modport slave (
        input  flush, in_vld, in_inst, in_pc, out_rdy,
        output in_rdy, out_vld, out_inst, out_pc, count
    );
endinterface
`default_nettype wire

// File: rtl/exu_inst_buf.sv
`default_nettype none
// ============================================================================
// exu_inst_buf : DEPTH-entry instruction FIFO between fetch and execute
// Revision 1.0
// ============================================================================
module exu_inst_buf #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int XLEN  = 32
) (
    input  wire              clk,
    input  wire              rst_n,
    exu_inst_buf_if.slave    bus
);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    logic [31:0]        inst_q [DEPTH];
    logic [XLEN-1:0]    pc_q   [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_ADDR_W-1:0] == rd_ptr_q[c_ADDR_W-1:0]) &&
                     (wr_ptr_q[c_ADDR_W] != rd_ptr_q[c_ADDR_W]);

    assign w_push = bus.in_vld  && !w_full  && !bus.flush;
    assign w_pop  = bus.out_rdy && !w_empty && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; entries are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            inst_q[wr_ptr_q[c_ADDR_W-1:0]] <= bus.in_inst;
            pc_q[wr_ptr_q[c_ADDR_W-1:0]]   <= bus.in_pc;
        end
    end

    assign bus.in_rdy   = !w_full;
    assign bus.out_vld  = !w_empty;
    assign bus.out_inst = inst_q[rd_ptr_q[c_ADDR_W-1:0]];
    assign bus.out_pc   = pc_q[rd_ptr_q[c_ADDR_W-1:0]];
    assign bus.count    = CNT_W'(wr_ptr_q - rd_ptr_q);
endmodule
`default_nettype wire

// File: doc/exu_inst_buf.md
# exu_inst_buf

Instruction buffer between the fetch unit and the execute stage. It accepts fetched instructions with their PC over a valid/ready handshake and stores them in a DEPTH-entry FIFO. It presents the oldest instruction to the EXU, where `out_vld` drives the handler `sel` inputs and `out_inst` drives their `inst` input. A flush input discards every buffered instruction, for use on taken branches, jumps and traps.

## Interface
- `DEPTH`, default 4: number of FIFO entries. Must be a power of 2 and ≥ 2.
- `CNT_W`, default $clog2(DEPTH)+1: width of the occupancy count.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous discard of all entries.
- `in_vld` input 1: fetch presents an instruction.
- `in_rdy` output 1: buffer can accept.
- `in_inst` input 32 (`rv32i_inst_t`): fetched instruction.
- `in_pc` input `RV_XLEN`: PC of `in_inst`.
- `out_vld` output 1: head entry valid.
- `out_rdy` input 1: EXU consumes the head this cycle.
- `out_inst` output 32 (`rv32i_inst_t`): head instruction.
- `out_pc` output `RV_XLEN`: head PC.
- `count` output CNT_W: current occupancy, 0..DEPTH.

## Operation
- Storage is a circular array of DEPTH entries, each holding {inst, pc}.
- Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits wide. The low bits index the array; the MSB is the wrap bit.
- Empty: `wr_ptr == rd_ptr`.
- Full: index bits are equal and the wrap bits differ.
- Push = `in_vld & in_rdy` (and `!flush`). It writes entry[wr_ptr index] and increments `wr_ptr` modulo 2·DEPTH.
- Pop = `out_vld & out_rdy` (and `!flush`). It increments `rd_ptr` modulo 2·DEPTH.
- `in_rdy = !full`. It is combinational from state only and never depends on `out_rdy` or `in_vld`.
- `out_vld = !empty`. `out_inst`/`out_pc` = entry[rd_ptr index], a combinational read of the registered array.
- `count = wr_ptr - rd_ptr`, computed modulo 2·DEPTH, so the value is always correct across wrap.
- Simultaneous push and pop when neither full nor empty: both pointers advance and `count` is unchanged.
- When full, no push occurs; a pop the same cycle frees a slot only from the next cycle.
- When empty, there is no pass-through; a pushed instruction becomes visible one cycle later.
- `flush` overrides everything:
  - `wr_ptr` and `rd_ptr` are set to 0 at the clock edge.
  - A concurrent push is dropped, even though `in_rdy` was 1.
  - A concurrent pop is discarded; the EXU must already have suppressed its result.
- Array contents are not reset and not cleared on flush. They are don't-care while `out_vld` = 0.
- `out_inst`/`out_pc` must stay stable while `out_vld` = 1 and `out_rdy` = 0.

## Timing
- Reset (`rst_n` = 0, asynchronous assert): pointers = 0 immediately, giving `out_vld` = 0, `in_rdy` = 1 and `count` = 0. Deassertion is synchronised upstream.
- Latency from push to `out_vld` is 1 cycle. From pop to the next head is 0 cycles: the head updates at the same edge.
- Throughput is 1 instruction/cycle sustained when both sides are ready and occupancy is between 1 and DEPTH-1.
- After a flush edge: `out_vld` = 0, `count` = 0, `in_rdy` = 1. The first post-flush push is accepted in the following cycle.
- Reset asserted mid-transfer: all entries are lost and no partial pointer update is visible.
- There are no combinational paths from `in_*` to `out_*`, or from `out_rdy` to `in_rdy`.

## Test plan
- Reset then single push (`in_inst` = 32'h00500093, `in_pc` = 32'h100) -> next cycle `out_vld` = 1, `out_inst` = 32'h00500093, `out_pc` = 32'h100, `count` = 1. Pop -> `out_vld` = 0.
- Fill with `out_rdy` = 0, pushing 5 instructions with DEPTH = 4 -> `in_rdy` = 0 after the 4th, 5th not accepted, `count` = 4. Drain -> the 4 instructions emerge in order.
- Streaming, `in_vld` = `out_rdy` = 1 for 20 cycles with incrementing PCs -> `count` stays 1, one instruction out per cycle, PCs in order, pointers wrap correctly.
- Full plus simultaneous pop and offered push -> push rejected that cycle (`in_rdy` = 0), `count` = 3 next cycle, push accepted the following cycle.
- Flush with `count` = 3 and a concurrent push -> next cycle `count` = 0, `out_vld` = 0. The pushed instruction never appears at the output.
- Asynchronous reset mid-stream with `count` = 2 -> `out_vld` falls without waiting for a clock edge. After release, the first new push is the head instruction.
